// File: rtl/mic_pkg.sv
// Shared constants for the microphone sample path (RAM, writer and reader).
// Defaults here are overridden per instance through module parameters.
package mic_pkg;

    localparam int MIC_ADDR_WIDTH = 6;
    localparam int MIC_DATA_WIDTH = 18;
    localparam int MIC_FRAME_LEN  = 64;
    localparam int MIC_DEPTH      = 2 ** MIC_ADDR_WIDTH;

    // Width of a counter that wraps every frame_len samples (frame_len is a power of two).
    function automatic int frame_cnt_width(input int frame_len);
        return (frame_len > 2) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/mic_fifo_reader_if.sv
// Valid/ready sample stream from the mic reader to the first analysis stage.
// master drives valid/data/last, slave drives ready.
interface mic_fifo_reader_if
    import mic_pkg::*;
#(
    parameter int DATA_WIDTH = MIC_DATA_WIDTH
);
    logic                  sample_valid;
    logic                  sample_ready;
    logic [DATA_WIDTH-1:0] sample_data;
    logic                  sample_last;

    modport master (
        output sample_valid,
        output sample_data,
        output sample_last,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        input  sample_last,
        output sample_ready
    );
endinterface

// File: rtl/mic_fifo_reader_skid.sv
// Two-entry FIFO-ordered output buffer that absorbs the RAM read latency.
// Exposes its entry count so the parent can bound reads in flight.
module mic_fifo_reader_skid
    import mic_pkg::*;
#(
    parameter int DATA_WIDTH = MIC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    logic [1:0]            r_count;
    logic                  w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_idx];
    assign o_count = r_count;
    assign w_pop   = o_valid && i_ready;

    // The parent never pushes into a full buffer, so push/pop need no guard here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_idx] <= i_push_data;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/mic_fifo_reader.sv
// Read-side controller for the mic sample RAM: level tracking, read issue, overrun detection.
// Optional frame marking on sample_last is built when MIC_FIFO_READER_FRAME_EN is defined.
module mic_fifo_reader
    import mic_pkg::*;
#(
    parameter int ADDR_WIDTH = MIC_ADDR_WIDTH,
    parameter int DATA_WIDTH = MIC_DATA_WIDTH,
    parameter int FRAME_LEN  = MIC_FRAME_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_we,
    output logic [ADDR_WIDTH-1:0] fifo_rd_addr,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    mic_fifo_reader_if.master     sample_if,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clear
);

    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_inflight;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_overrun;
    logic                  w_last;
    logic [1:0]            w_skid_count;
    logic [2:0]            w_occ_after;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_pop       = w_valid && sample_if.sample_ready;
    // Occupancy after this cycle's pop; a pop always implies a buffered entry, so no underflow.
    assign w_occ_after = {2'b00, r_inflight} + {1'b0, w_skid_count} - {2'b00, w_pop};
    assign w_issue     = (r_level != '0) && (w_occ_after < 3'd2);
    assign w_overrun   = fifo_we && (r_level == LEVEL_FULL) && !w_issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            // On overrun the writer has overwritten the oldest unread slot; skip past it.
            if (w_issue || w_overrun) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (fifo_we && !w_issue && !w_overrun) begin
                r_level <= r_level + 1'b1;
            end else if (!fifo_we && w_issue) begin
                r_level <= r_level - 1'b1;
            end
            if (w_overrun) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    mic_fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_inflight),
        .i_push_data (fifo_rd_data),
        .i_ready     (sample_if.sample_ready),
        .o_valid     (w_valid),
        .o_data      (w_data),
        .o_count     (w_skid_count)
    );

`ifdef MIC_FIFO_READER_FRAME_EN
    localparam int FCW = frame_cnt_width(FRAME_LEN);
    logic [FCW-1:0] r_frame_cnt;

    // Realign frames after data loss so downstream frames never straddle a gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_overrun) begin
            r_frame_cnt <= '0;
        end else if (w_pop) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign w_last = w_valid && (r_frame_cnt == FCW'(FRAME_LEN - 1));
`else
    assign w_last = 1'b0;
`endif

    assign fifo_rd_addr           = r_rd_ptr;
    assign level                  = r_level;
    assign overflow               = r_overflow;
    assign sample_if.sample_valid = w_valid;
    assign sample_if.sample_data  = w_data;
    assign sample_if.sample_last  = w_last;

endmodule

// File: tb/tb_mic_fifo_reader.sv
// Directed bench for mic_fifo_reader with a read-before-write RAM and counting writer model.
// Frame checks are compiled in when MIC_FIFO_READER_FRAME_EN is defined (FRAME_LEN 4).
module tb_mic_fifo_reader;

    localparam int AW    = 6;
    localparam int DW    = 18;
    localparam int FL    = 4;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_we = 1'b0;
    logic          ovf_clear = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] fifo_rd_addr;
    logic [DW-1:0] fifo_rd_data;
    logic [AW:0]   level;
    logic          overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int vcount = 0;

    logic [DW-1:0] got[$];
    logic          got_last[$];
    int            got_cyc[$];

    always #5 clk = ~clk;

    mic_fifo_reader_if #(.DATA_WIDTH(DW)) sif ();

    mic_fifo_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_we      (fifo_we),
        .fifo_rd_addr (fifo_rd_addr),
        .fifo_rd_data (fifo_rd_data),
        .sample_if    (sif),
        .level        (level),
        .overflow     (overflow),
        .ovf_clear    (ovf_clear)
    );

    // RAM model: registered read port, read-before-write, writer address counts fifo_we.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] wptr;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    end

    always @(posedge clk) begin
        if (fifo_we) ram[wptr] <= wdata;
        fifo_rd_data <= ram[fifo_rd_addr];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) wptr <= '0;
        else if (fifo_we) wptr <= wptr + 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && sif.sample_valid && sif.sample_ready) begin
            got.push_back(sif.sample_data);
            got_last.push_back(sif.sample_last);
            got_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] val(input int n);
        return DW'(n * 7 + 'h01000);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    task automatic wait_got(input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        step();
        step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_got();
    endtask

    task automatic test_reset();
        sif.sample_ready = 1'b0;
        step();
        tests++; if (fifo_rd_addr !== '0) begin fails++; $display("FAIL reset_addr: got %0h expected 0", fifo_rd_addr); end
        tests++; if (sif.sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", sif.sample_valid); end
        tests++; if (sif.sample_data !== '0) begin fails++; $display("FAIL reset_data: got %0h expected 0", sif.sample_data); end
        tests++; if (sif.sample_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %0b expected 0", sif.sample_last); end
        tests++; if (level !== '0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        reset = 1'b0;
        clear_got();
    endtask

    task automatic test_single();
        logic [DW-1:0] v;
        sif.sample_ready = 1'b1;
        v = val(vcount); vcount++;
        fifo_we = 1'b1; wdata = v;
        step();
        fifo_we = 1'b0;
        tests++; if (fifo_rd_addr !== 6'd0 || level !== 7'd1) begin fails++; $display("FAIL single_issue: addr %0d level %0d expected addr 0 level 1", fifo_rd_addr, level); end
        step();
        tests++; if (sif.sample_valid !== 1'b0) begin fails++; $display("FAIL single_latency: valid %0b in cycle 2 expected 0", sif.sample_valid); end
        step();
        tests++; if (sif.sample_valid !== 1'b1 || sif.sample_data !== v) begin fails++; $display("FAIL single_data: valid %0b data %0h expected 1 %0h", sif.sample_valid, sif.sample_data, v); end
        step();
        tests++; if (level !== 7'd0 || got.size() != 1 || sif.sample_valid !== 1'b0) begin fails++; $display("FAIL single_drain: level %0d count %0d valid %0b expected 0 1 0", level, got.size(), sif.sample_valid); end
    endtask

    task automatic test_burst();
        logic [DW-1:0] vals[$];
        int max_lvl, bad, gaps;
        clear_got();
        sif.sample_ready = 1'b1;
        max_lvl = 0;
        for (int i = 0; i < 10; i++) begin
            vals.push_back(val(vcount)); vcount++;
            fifo_we = 1'b1; wdata = vals[i];
            step();
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        fifo_we = 1'b0;
        wait_got(10, 20);
        tests++; if (got.size() != 10) begin fails++; $display("FAIL burst_count: got %0d samples expected 10", got.size()); end
        bad = 0; gaps = 0;
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            if (got[i] !== vals[i]) bad++;
            if (i > 0 && got_cyc[i] - got_cyc[i-1] != 1) gaps++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL burst_data: %0d wrong samples expected 0", bad); end
        tests++; if (gaps != 0) begin fails++; $display("FAIL burst_gaps: %0d bubbles expected 0", gaps); end
        tests++; if (max_lvl > 2 || overflow !== 1'b0) begin fails++; $display("FAIL burst_level: peak %0d overflow %0b expected <=2 and 0", max_lvl, overflow); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vals[$];
        int unstable, bad, gaps;
        clear_got();
        sif.sample_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vals.push_back(val(vcount)); vcount++;
            fifo_we = 1'b1; wdata = vals[i];
            step();
        end
        fifo_we = 1'b0;
        unstable = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (sif.sample_valid !== 1'b1 || sif.sample_data !== vals[0]) unstable++;
        end
        tests++; if (unstable != 0) begin fails++; $display("FAIL bp_stable: %0d unstable cycles expected 0", unstable); end
        tests++; if (level !== 7'd6 || got.size() != 0) begin fails++; $display("FAIL bp_level: level %0d accepted %0d expected 6 0", level, got.size()); end
        sif.sample_ready = 1'b1;
        wait_got(8, 30);
        tests++; if (got.size() != 8) begin fails++; $display("FAIL bp_count: got %0d samples expected 8", got.size()); end
        bad = 0; gaps = 0;
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            if (got[i] !== vals[i]) bad++;
            if (i > 0 && got_cyc[i] - got_cyc[i-1] != 1) gaps++;
        end
        tests++; if (bad != 0 || gaps != 0) begin fails++; $display("FAIL bp_order: %0d wrong %0d bubbles expected 0 0", bad, gaps); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] vals[$];
        logic [DW-1:0] exp[$];
        int bad;
        clear_got();
        sif.sample_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            vals.push_back(val(vcount)); vcount++;
            fifo_we = 1'b1; wdata = vals[i];
            step();
        end
        fifo_we = 1'b0;
        step();
        step();
        tests++; if (overflow !== 1'b1 || level !== 7'd64) begin fails++; $display("FAIL ovr_flag: overflow %0b level %0d expected 1 64", overflow, level); end
        // Two samples sit in the buffer; the 67th write overwrote sample 2 while it was unread.
        for (int i = 0; i < DEPTH + 3; i++) if (i != 2) exp.push_back(vals[i]);
        sif.sample_ready = 1'b1;
        wait_got(exp.size(), 200);
        tests++; if (got.size() != exp.size()) begin fails++; $display("FAIL ovr_count: got %0d samples expected %0d", got.size(), exp.size()); end
        bad = 0;
        for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] !== exp[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL ovr_data: %0d wrong samples expected 0", bad); end
        tests++; if (overflow !== 1'b1 || level !== 7'd0) begin fails++; $display("FAIL ovr_sticky: overflow %0b level %0d expected 1 0", overflow, level); end
        ovf_clear = 1'b1;
        step();
        ovf_clear = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovr_clear: overflow %0b expected 0", overflow); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] vals[$];
        logic [AW-1:0] prev;
        int wraps, lvl_bad, bad, last_bad;
        logic exp_last;
        apply_reset();
        sif.sample_ready = 1'b1;
        wraps = 0; lvl_bad = 0;
        prev = fifo_rd_addr;
        for (int i = 0; i < 200; i++) begin
            vals.push_back(val(vcount)); vcount++;
            fifo_we = 1'b1; wdata = vals[i];
            step();
            if (prev == 6'd63 && fifo_rd_addr == 6'd0) wraps++;
            prev = fifo_rd_addr;
            if (level !== 7'd1) lvl_bad++;
        end
        fifo_we = 1'b0;
        for (int k = 0; k < 30 && got.size() < 200; k++) begin
            step();
            if (prev == 6'd63 && fifo_rd_addr == 6'd0) wraps++;
            prev = fifo_rd_addr;
        end
        step();
        tests++; if (got.size() != 200) begin fails++; $display("FAIL wrap_count: got %0d samples expected 200", got.size()); end
        tests++; if (wraps != 3) begin fails++; $display("FAIL wrap_addr: %0d wraps 63->0 expected 3", wraps); end
        tests++; if (lvl_bad != 0 || overflow !== 1'b0) begin fails++; $display("FAIL wrap_level: %0d cycles level!=1 overflow %0b expected 0 0", lvl_bad, overflow); end
        bad = 0; last_bad = 0;
        for (int i = 0; i < 200 && i < got.size(); i++) begin
            if (got[i] !== vals[i]) bad++;
`ifdef MIC_FIFO_READER_FRAME_EN
            exp_last = ((i % FL) == FL - 1);
`else
            exp_last = 1'b0;
`endif
            if (got_last[i] !== exp_last) last_bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL wrap_data: %0d wrong samples expected 0", bad); end
        tests++; if (last_bad != 0) begin fails++; $display("FAIL wrap_last: %0d wrong last flags expected 0", last_bad); end
    endtask

    task automatic test_async_reset();
        clear_got();
        sif.sample_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fifo_we = 1'b1; wdata = val(vcount); vcount++;
            step();
        end
        fifo_we = 1'b0;
        sif.sample_ready = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        tests++; if (sif.sample_valid !== 1'b0 || sif.sample_data !== '0 || sif.sample_last !== 1'b0) begin fails++; $display("FAIL areset_stream: valid %0b data %0h last %0b expected 0 0 0", sif.sample_valid, sif.sample_data, sif.sample_last); end
        tests++; if (level !== '0 || fifo_rd_addr !== '0 || overflow !== 1'b0) begin fails++; $display("FAIL areset_state: level %0d addr %0d overflow %0b expected 0 0 0", level, fifo_rd_addr, overflow); end
        step();
        reset = 1'b0;
        clear_got();
        sif.sample_ready = 1'b1;
        step();
        step();
        step();
        tests++; if (sif.sample_valid !== 1'b0 || got.size() != 0) begin fails++; $display("FAIL areset_flush: valid %0b accepted %0d expected 0 0", sif.sample_valid, got.size()); end
`ifdef MIC_FIFO_READER_FRAME_EN
        for (int i = 0; i < FL; i++) begin
            fifo_we = 1'b1; wdata = val(vcount); vcount++;
            step();
        end
        fifo_we = 1'b0;
        wait_got(FL, 20);
        tests++;
        if (got.size() != FL || got_last[0] !== 1'b0 || got_last[FL-2] !== 1'b0 || got_last[FL-1] !== 1'b1) begin
            fails++;
            $display("FAIL frame_restart: %0d samples, last flag of sample %0d wrong or count off, expected last only on sample %0d", got.size(), FL, FL);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_overrun();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
